parallax_scene_sequencer: RTL and testbench

- Frame-level controller for the multi-layer LFSR parallax background.
- Holds host-written per-layer configuration: scroll speed, direction, seed and enable.
- Once per frame it advances each layer's fractional scroll accumulator and publishes offsets and seeds to the layer datapaths.
- Sits between the host configuration port and the layer LFSR/mountain generators; timing comes from the VGA sync generator's frame-start strobe.

---
 rtl/parallax_scene_sequencer.sv | 172 +++++++++++++++++
 tb/tb_parallax_scene_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parallax_scene_sequencer.sv
// Frame-level sequencer for the LFSR parallax background: holds per-layer scroll/seed
// configuration from the host and publishes offsets and seeds once per frame.

module parallax_scene_sequencer #(
   parameter int unsigned NUM_LAYERS   = 3,
   parameter int unsigned OFFSET_W     = 10,
   parameter int unsigned FRAC_BITS    = 4,
   parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           frame_start,
   input  logic                           cfg_valid,
   output logic                           cfg_ready,
   input  logic [3:0]                     cfg_addr,
   input  logic [15:0]                    cfg_data,
   input  logic                           step,
   output logic [NUM_LAYERS*OFFSET_W-1:0] layer_offset,
   output logic [NUM_LAYERS*16-1:0]       layer_seed,
   output logic [NUM_LAYERS-1:0]          layer_enable,
   output logic                           seed_load,
   output logic [7:0]                     frame_count,
   output logic                           overrun
);

   localparam int unsigned ACC_W = OFFSET_W + FRAC_BITS;
   localparam int unsigned IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);

   typedef enum logic [1:0] {StWait, StLatch, StStep, StPublish} state_e;

   state_e state;
   logic [IDX_W-1:0] idx;
   logic adv;
   logic step_pending;
   logic clear_pending;

   // Host-visible shadow configuration
   logic                  sh_run;
   logic [NUM_LAYERS-1:0] sh_en;
   logic [7:0]            sh_speed [NUM_LAYERS];
   logic                  sh_dir   [NUM_LAYERS];
   logic [15:0]           sh_seed  [NUM_LAYERS];

   // Configuration frozen for the frame being computed
   logic [NUM_LAYERS-1:0] act_en;
   logic [7:0]            act_speed [NUM_LAYERS];
   logic                  act_dir   [NUM_LAYERS];
   logic [15:0]           act_seed  [NUM_LAYERS];

   logic [ACC_W-1:0] acc [NUM_LAYERS];

   logic cfg_fire;
   logic ctrl_wr;
   logic [ACC_W-1:0] cur_acc;
   logic [ACC_W-1:0] speed_ext;
   logic [ACC_W-1:0] next_acc;

   assign cfg_fire = cfg_valid && cfg_ready;
   assign ctrl_wr  = cfg_fire && (cfg_addr == 4'd0);

   always_comb begin
      cur_acc   = acc[idx];
      speed_ext = ACC_W'(act_speed[idx]);
      next_acc  = act_dir[idx] ? (cur_acc - speed_ext) : (cur_acc + speed_ext);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sh_run <= 1'b0;
         sh_en  <= '1;
         for (int i = 0; i < NUM_LAYERS; i++) begin
            sh_speed[i] <= 8'd0;
            sh_dir[i]   <= 1'b0;
            sh_seed[i]  <= DEFAULT_SEED;
         end
      end else begin
         if (ctrl_wr) begin
            sh_run <= cfg_data[0];
            sh_en  <= cfg_data[2 +: NUM_LAYERS];
         end
         for (int i = 0; i < NUM_LAYERS; i++) begin
            if (cfg_fire && (cfg_addr == 4'(i + 1))) begin
               sh_speed[i] <= cfg_data[7:0];
               sh_dir[i]   <= cfg_data[8];
            end
            if (cfg_fire && (cfg_addr == 4'(NUM_LAYERS + 1 + i))) begin
               // Zero would lock an LFSR up, so substitute the default seed
               sh_seed[i] <= (cfg_data == 16'd0) ? DEFAULT_SEED : cfg_data;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= StWait;
         idx           <= '0;
         adv           <= 1'b0;
         step_pending  <= 1'b0;
         clear_pending <= 1'b0;
         cfg_ready     <= 1'b1;
         act_en        <= '1;
         for (int i = 0; i < NUM_LAYERS; i++) begin
            act_speed[i] <= 8'd0;
            act_dir[i]   <= 1'b0;
            act_seed[i]  <= DEFAULT_SEED;
            acc[i]       <= '0;
         end
         layer_offset <= '0;
         layer_seed   <= {NUM_LAYERS{DEFAULT_SEED}};
         layer_enable <= '1;
         seed_load    <= 1'b0;
         frame_count  <= 8'd0;
         overrun      <= 1'b0;
      end else begin
         seed_load <= 1'b0;
         if (step) step_pending <= 1'b1;
         if (ctrl_wr && cfg_data[1]) clear_pending <= 1'b1;
         if (ctrl_wr && cfg_data[8]) overrun <= 1'b0;
         if (frame_start && (state != StWait)) overrun <= 1'b1;

         case (state)
            StWait: begin
               if (frame_start) begin
                  state     <= StLatch;
                  cfg_ready <= 1'b0;
               end
            end
            StLatch: begin
               act_en <= sh_en;
               for (int i = 0; i < NUM_LAYERS; i++) begin
                  act_speed[i] <= sh_speed[i];
                  act_dir[i]   <= sh_dir[i];
                  act_seed[i]  <= sh_seed[i];
                  if (clear_pending) acc[i] <= '0;
               end
               clear_pending <= 1'b0;
               adv           <= sh_run || step_pending || step;
               idx           <= '0;
               state         <= StStep;
            end
            StStep: begin
               if (adv && act_en[idx]) acc[idx] <= next_acc;
               if (idx == LAST_IDX) begin
                  state <= StPublish;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            StPublish: begin
               for (int i = 0; i < NUM_LAYERS; i++) begin
                  layer_offset[i*OFFSET_W +: OFFSET_W] <= acc[i][ACC_W-1 -: OFFSET_W];
                  layer_seed[i*16 +: 16]               <= act_seed[i];
               end
               layer_enable <= act_en;
               seed_load    <= 1'b1;
               if (adv) frame_count <= frame_count + 8'd1;
               // A step arriving during publish belongs to the next frame
               step_pending <= step;
               cfg_ready    <= 1'b1;
               state        <= StWait;
            end
            default: begin
               state     <= StWait;
               cfg_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_parallax_scene_sequencer.sv
// Directed bench for parallax_scene_sequencer with NUM_LAYERS=3, OFFSET_W=10, FRAC_BITS=4.

module tb_parallax_scene_sequencer;

   localparam int N  = 3;
   localparam int OW = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          frame_start;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [3:0]    cfg_addr;
   logic [15:0]   cfg_data;
   logic          step;
   logic [N*OW-1:0] layer_offset;
   logic [N*16-1:0] layer_seed;
   logic [N-1:0]  layer_enable;
   logic          seed_load;
   logic [7:0]    frame_count;
   logic          overrun;

   int tests = 0;
   int fails = 0;

   parallax_scene_sequencer #(
      .NUM_LAYERS(N),
      .OFFSET_W(OW),
      .FRAC_BITS(4),
      .DEFAULT_SEED(16'hACE1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .frame_start(frame_start),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_addr(cfg_addr),
      .cfg_data(cfg_data),
      .step(step),
      .layer_offset(layer_offset),
      .layer_seed(layer_seed),
      .layer_enable(layer_enable),
      .seed_load(seed_load),
      .frame_count(frame_count),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic wr(input logic [3:0] a, input logic [15:0] d);
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_addr  = a;
      cfg_data  = d;
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   // Returns edges from frame_start sample to visible publish, or -1 on timeout
   task automatic do_frame(output int lat);
      lat = -1;
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      for (int k = 2; k <= 20; k++) begin
         @(negedge clk);
         if (seed_load) begin
            lat = k - 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if (cfg_ready !== 1'b1 || seed_load !== 1'b0 || overrun !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctl: ready=%b seed_load=%b overrun=%b want 1 0 0",
                  cfg_ready, seed_load, overrun);
      end
      tests++;
      if (layer_offset !== '0 || frame_count !== 8'd0) begin
         fails++;
         $display("FAIL reset_cnt: offset=%h fc=%0d want 0 0", layer_offset, frame_count);
      end
      tests++;
      if (layer_seed !== 48'hACE1ACE1ACE1 || layer_enable !== 3'b111) begin
         fails++;
         $display("FAIL reset_seed: seed=%h en=%b want ace1ace1ace1 111", layer_seed, layer_enable);
      end
      reset = 1'b1;
   endtask

   task automatic test_idle_frames();
      int lat;
      for (int f = 0; f < 3; f++) begin
         do_frame(lat);
         tests++;
         if (lat !== 5) begin
            fails++;
            $display("FAIL idle_seed_load: frame %0d latency=%0d want 5", f, lat);
         end
      end
      tests++;
      if (layer_offset !== '0 || frame_count !== 8'd0 || layer_seed !== 48'hACE1ACE1ACE1) begin
         fails++;
         $display("FAIL idle_state: offset=%h fc=%0d seed=%h want 0 0 ace1ace1ace1",
                  layer_offset, frame_count, layer_seed);
      end
   endtask

   task automatic test_scroll();
      int lat;
      wr(4'd1, 16'h0018);
      wr(4'd0, 16'h001D);
      do_frame(lat);
      tests++;
      if (lat !== 5 || layer_offset[0 +: OW] !== 10'd1) begin
         fails++;
         $display("FAIL scroll_f1: lat=%0d off0=%0d want 5 1", lat, layer_offset[0 +: OW]);
      end
      do_frame(lat);
      tests++;
      if (lat !== 5 || layer_offset[0 +: OW] !== 10'd3) begin
         fails++;
         $display("FAIL scroll_f2: lat=%0d off0=%0d want 5 3", lat, layer_offset[0 +: OW]);
      end
      tests++;
      if (frame_count !== 8'd2 || layer_offset[OW +: 2*OW] !== '0) begin
         fails++;
         $display("FAIL scroll_fc: fc=%0d off12=%h want 2 0", frame_count, layer_offset[OW +: 2*OW]);
      end
   endtask

   task automatic test_wrap_disable();
      int lat;
      wr(4'd2, 16'h0110);
      wr(4'd3, 16'h0020);
      wr(4'd0, 16'h000D);
      do_frame(lat);
      tests++;
      if (layer_offset[OW +: OW] !== 10'd1023) begin
         fails++;
         $display("FAIL wrap_l1: off1=%0d want 1023", layer_offset[OW +: OW]);
      end
      tests++;
      if (layer_offset[2*OW +: OW] !== 10'd0 || layer_enable !== 3'b011) begin
         fails++;
         $display("FAIL disabled_l2: off2=%0d en=%b want 0 011", layer_offset[2*OW +: OW], layer_enable);
      end
      tests++;
      if (layer_offset[0 +: OW] !== 10'd4 || frame_count !== 8'd3) begin
         fails++;
         $display("FAIL wrap_l0: off0=%0d fc=%0d want 4 3", layer_offset[0 +: OW], frame_count);
      end
   endtask

   task automatic test_seeds();
      int lat;
      wr(4'd6, 16'h0000);
      wr(4'd5, 16'hBEEF);
      do_frame(lat);
      tests++;
      if (layer_seed[32 +: 16] !== 16'hACE1 || layer_seed[16 +: 16] !== 16'hBEEF) begin
         fails++;
         $display("FAIL seed_zero_sub: s2=%h s1=%h want ace1 beef", layer_seed[32 +: 16], layer_seed[16 +: 16]);
      end
      // Write lands in the same cycle frame_start is sampled
      @(negedge clk);
      cfg_valid   = 1'b1;
      cfg_addr    = 4'd4;
      cfg_data    = 16'h1234;
      frame_start = 1'b1;
      @(negedge clk);
      cfg_valid   = 1'b0;
      frame_start = 1'b0;
      lat = -1;
      for (int k = 2; k <= 20; k++) begin
         @(negedge clk);
         if (seed_load) begin
            lat = k - 1;
            break;
         end
      end
      tests++;
      if (lat !== 5 || layer_seed[0 +: 16] !== 16'h1234) begin
         fails++;
         $display("FAIL seed_same_frame: lat=%0d s0=%h want 5 1234", lat, layer_seed[0 +: 16]);
      end
      tests++;
      if (frame_count !== 8'd5) begin
         fails++;
         $display("FAIL seed_fc: fc=%0d want 5", frame_count);
      end
   endtask

   task automatic test_step();
      int lat;
      wr(4'd1, 16'h0010);
      wr(4'd2, 16'h0000);
      wr(4'd3, 16'h0000);
      wr(4'd0, 16'h001E);
      do_frame(lat);
      tests++;
      if (layer_offset !== '0 || frame_count !== 8'd5) begin
         fails++;
         $display("FAIL clear_offsets: offset=%h fc=%0d want 0 5", layer_offset, frame_count);
      end
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      do_frame(lat);
      tests++;
      if (layer_offset[0 +: OW] !== 10'd1 || frame_count !== 8'd6) begin
         fails++;
         $display("FAIL step_once: off0=%0d fc=%0d want 1 6", layer_offset[0 +: OW], frame_count);
      end
      do_frame(lat);
      do_frame(lat);
      tests++;
      if (lat !== 5 || layer_offset[0 +: OW] !== 10'd1 || frame_count !== 8'd6) begin
         fails++;
         $display("FAIL step_paused: lat=%0d off0=%0d fc=%0d want 5 1 6",
                  lat, layer_offset[0 +: OW], frame_count);
      end
   endtask

   task automatic test_overrun();
      int lat;
      int extra;
      wr(4'd0, 16'h001D);
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      lat = -1;
      for (int k = 4; k <= 20; k++) begin
         if (seed_load && lat < 0) lat = k - 2;
         if (lat >= 0) break;
         @(negedge clk);
      end
      tests++;
      if (lat !== 5 || overrun !== 1'b1) begin
         fails++;
         $display("FAIL overrun_set: lat=%0d overrun=%b want 5 1", lat, overrun);
      end
      extra = 0;
      repeat (12) begin
         @(negedge clk);
         if (seed_load) extra++;
      end
      tests++;
      if (extra !== 0 || frame_count !== 8'd7 || layer_offset[0 +: OW] !== 10'd2) begin
         fails++;
         $display("FAIL overrun_no_update: extra=%0d fc=%0d off0=%0d want 0 7 2",
                  extra, frame_count, layer_offset[0 +: OW]);
      end
      wr(4'd0, 16'h011D);
      tests++;
      if (overrun !== 1'b0) begin
         fails++;
         $display("FAIL overrun_clear: overrun=%b want 0", overrun);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      int stalled;
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      cfg_valid   = 1'b1;
      cfg_addr    = 4'd2;
      cfg_data    = 16'h0020;
      stalled     = 0;
      for (int k = 0; k < 20; k++) begin
         if (cfg_ready === 1'b1) break;
         stalled++;
         @(negedge clk);
      end
      @(negedge clk);
      cfg_valid = 1'b0;
      tests++;
      if (stalled !== 5) begin
         fails++;
         $display("FAIL stall_cycles: stalled=%0d want 5", stalled);
      end
      do_frame(lat);
      tests++;
      if (layer_offset[OW +: OW] !== 10'd2 || layer_offset[0 +: OW] !== 10'd4 ||
          frame_count !== 8'd9) begin
         fails++;
         $display("FAIL stall_accept: off1=%0d off0=%0d fc=%0d want 2 4 9",
                  layer_offset[OW +: OW], layer_offset[0 +: OW], frame_count);
      end
   endtask

   task automatic test_reset_mid();
      int pulses;
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      tests++;
      if (layer_offset !== '0 || frame_count !== 8'd0 || seed_load !== 1'b0 ||
          cfg_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_mid: offset=%h fc=%0d seed_load=%b ready=%b want 0 0 0 1",
                  layer_offset, frame_count, seed_load, cfg_ready);
      end
      tests++;
      if (layer_seed !== 48'hACE1ACE1ACE1 || layer_enable !== 3'b111) begin
         fails++;
         $display("FAIL reset_mid_seed: seed=%h en=%b want ace1ace1ace1 111", layer_seed, layer_enable);
      end
      @(negedge clk);
      reset  = 1'b1;
      pulses = 0;
      repeat (10) begin
         @(negedge clk);
         if (seed_load) pulses++;
      end
      tests++;
      if (pulses !== 0 || frame_count !== 8'd0) begin
         fails++;
         $display("FAIL reset_mid_publish: pulses=%0d fc=%0d want 0 0", pulses, frame_count);
      end
   endtask

   initial begin
      frame_start = 1'b0;
      cfg_valid   = 1'b0;
      cfg_addr    = 4'd0;
      cfg_data    = 16'd0;
      step        = 1'b0;
      test_reset();
      test_idle_frames();
      test_scroll();
      test_wrap_disable();
      test_seeds();
      test_step();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
